// File: rtl/pwm_audio_pkg.sv
// pwm_audio_pkg: mode encoding and default dimensions shared by the
// multichannel audio DAC and its per-channel modulator.
package pwm_audio_pkg;
    localparam logic MODE_PWM     = 1'b0;
    localparam logic MODE_DSM     = 1'b1;
    localparam int   DEF_WIDTH    = 12;
    localparam int   DEF_CHANNELS = 2;
    localparam int   DEF_PERIOD   = 4095;
endpackage

// File: rtl/pwm_audio_ch.sv
// pwm_audio_ch: one DAC channel, PWM compare against the frame counter or a
// first-order delta-sigma accumulator whose carry is the output bit.
module pwm_audio_ch import pwm_audio_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             dsm_i,
    input  logic [WIDTH-1:0] cnt_i,
    input  logic [WIDTH-1:0] level_i,
    output logic             pwm_o
);
    logic [WIDTH:0] acc_q, acc_d;
    logic           pwm_q, pwm_d;

    always_comb begin
        acc_d = clr_i ? '0 : {1'b0, acc_q[WIDTH-1:0]} + {1'b0, level_i};
        pwm_d = cnt_i < level_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            pwm_q <= pwm_d;
        end
    end

    // Both sources are register bits, so the output stays glitch-free per mode.
    assign pwm_o = dsm_i ? acc_q[WIDTH] : pwm_q;
endmodule

// File: rtl/pwm_audio_mc.sv
// pwm_audio_mc: multichannel PWM / delta-sigma audio DAC with a frame counter,
// double-buffered sample frames, frame tick and sticky underrun flag.
module pwm_audio_mc import pwm_audio_pkg::*; #(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int PERIOD   = DEF_PERIOD
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [CHANNELS*WIDTH-1:0] s_data,
    input  logic                      mode,
    output logic [CHANNELS-1:0]       pwm,
    output logic                      frame_tick,
    output logic                      underrun
);
    localparam logic [WIDTH-1:0] LAST = WIDTH'(PERIOD - 1);
    localparam logic [WIDTH-1:0] MID  = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0]          cnt_q, cnt_d;
    logic [CHANNELS*WIDTH-1:0] pend_q, pend_d, act_q, act_d;
    logic                      pend_full_q, pend_full_d;
    logic                      mode_act_q, mode_act_d;
    logic                      tick_q, tick_d, under_q, under_d;
    logic                      boundary, accept, load, clr;

    always_comb begin
        boundary    = cnt_q == LAST;
        accept      = s_valid & ~pend_full_q;
        load        = boundary & pend_full_q;
        clr         = load & (mode != mode_act_q);
        cnt_d       = boundary ? '0 : cnt_q + 1'b1;
        pend_d      = accept ? s_data : pend_q;
        // A frame accepted on an empty boundary only fills pending; no bypass.
        pend_full_d = accept | (pend_full_q & ~boundary);
        act_d       = load ? pend_q : act_q;
        mode_act_d  = load ? mode : mode_act_q;
        tick_d      = boundary;
        under_d     = under_q | (boundary & ~pend_full_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            act_q       <= {CHANNELS{MID}};
            mode_act_q  <= MODE_PWM;
            tick_q      <= 1'b0;
            under_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            act_q       <= act_d;
            mode_act_q  <= mode_act_d;
            tick_q      <= tick_d;
            under_q     <= under_d;
        end
    end

    assign s_ready    = ~pend_full_q;
    assign frame_tick = tick_q;
    assign underrun   = under_q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        pwm_audio_ch #(.WIDTH(WIDTH)) u_ch (
            .clk     (clk),
            .rst     (rst),
            .clr_i   (clr),
            .dsm_i   (mode_act_q == MODE_DSM),
            .cnt_i   (cnt_q),
            .level_i (act_q[c*WIDTH +: WIDTH]),
            .pwm_o   (pwm[c])
        );
    end
endmodule
